// File: rtl/flag_register_unit.sv
// rtl/flag_register_unit.sv - condition-flag register with derived P flag and save/restore stack
module flag_register_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] res,
  input  logic             cout,
  input  logic [1:0]       op_class,
  input  logic [3:0]       flag_in,
  input  logic [3:0]       flag_mask,
  input  logic             flag_we,
  input  logic             save,
  input  logic             restore,
  output logic [4:0]       r_flag,
  output logic             stk_empty,
  output logic             stk_full,
  output logic             err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOGIC = 2'b10;

  logic [3:0]    flags;            // {O,C,N,Z}
  logic [3:0]    stk [DEPTH];
  logic [CW-1:0] count;
  logic [3:0]    calc;
  logic [AW-1:0] push_idx;
  logic [AW-1:0] top_idx;
  logic          save_only;
  logic          restore_only;
  logic          err_next;

  always_comb begin
    calc = 4'b0000;
    calc[0] = (res == '0);
    calc[1] = res[WIDTH-1];
    case (op_class)
      OP_ADD: begin
        calc[2] = cout;
        calc[3] = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        calc[2] = cout;
        calc[3] = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_LOGIC: begin
        calc[2] = 1'b0;
        calc[3] = 1'b0;
      end
      default: calc = flag_in;
    endcase
  end

  assign stk_empty    = (count == '0);
  assign stk_full     = (count == CW'(DEPTH));
  assign save_only    = save && !restore;
  assign restore_only = restore && !save;
  assign push_idx     = AW'(count);
  assign top_idx      = AW'(count - 1'b1);
  assign err_next     = (save && restore) || (save_only && stk_full) || (restore_only && stk_empty);

  // P is recomputed from the registered Z/N so it never needs to be stacked
  assign r_flag = {~flags[0] & ~flags[1], flags};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 4'b0000;
      count <= '0;
      err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk[i] <= 4'b0000;
    end else begin
      err <= err_next;
      if (save_only && !stk_full) begin
        stk[push_idx] <= flags;
        count         <= count + 1'b1;
      end
      // a restore request, even on an empty stack, suppresses the flag update
      if (restore_only) begin
        if (!stk_empty) begin
          flags <= stk[top_idx];
          count <= count - 1'b1;
        end
      end else if (flag_we) begin
        flags <= (flags & ~flag_mask) | (calc & flag_mask);
      end
    end
  end

endmodule

// File: tb/tb_flag_register_unit.sv
// tb/tb_flag_register_unit.sv - directed self-checking bench for flag_register_unit
module tb_flag_register_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b, res;
  logic       cout;
  logic [1:0] op_class;
  logic [3:0] flag_in, flag_mask;
  logic       flag_we, save, restore;
  logic [4:0] r_flag;
  logic       stk_empty, stk_full, err;

  int checks = 0;
  int failures = 0;

  flag_register_unit #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .res(res), .cout(cout),
    .op_class(op_class), .flag_in(flag_in), .flag_mask(flag_mask),
    .flag_we(flag_we), .save(save), .restore(restore), .r_flag(r_flag),
    .stk_empty(stk_empty), .stk_full(stk_full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] with_p(input logic [3:0] f);
    return {~f[0] & ~f[1], f};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flag_we = 0; save = 0; restore = 0;
  endtask

  task automatic alu(input logic [1:0] op, input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] rv, input logic cv, input logic [3:0] m);
    op_class = op; a = av; b = bv; res = rv; cout = cv; flag_mask = m; flag_we = 1;
  endtask

  task automatic load(input logic [3:0] v);
    op_class = 2'b11; flag_in = v; flag_mask = 4'hF; flag_we = 1;
    a = 8'h00; b = 8'h00; res = 8'h00; cout = 1'b1;
  endtask

  initial begin
    rst_n = 0; a = 0; b = 0; res = 0; cout = 0; op_class = 0;
    flag_in = 0; flag_mask = 0; idle();
    #12;
    check("rst_rflag", 8'(r_flag), 8'h10);
    check("rst_empty", 8'(stk_empty), 8'd1);
    check("rst_full", 8'(stk_full), 8'd0);
    check("rst_err", 8'(err), 8'd0);
    @(negedge clk);
    rst_n = 1;

    // add overflow into sign bit
    step(); alu(2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 4'hF);
    step(); idle();
    check("add_ovf", 8'(r_flag), 8'h0A);

    alu(2'b01, 8'h05, 8'h05, 8'h00, 1'b1, 4'hF);
    step(); idle();
    check("sub_zero", 8'(r_flag), 8'h05);
    alu(2'b01, 8'h80, 8'h01, 8'h7F, 1'b1, 4'hF);
    step(); idle();
    check("sub_ovf", 8'(r_flag), 8'h1C);

    // masked logic update keeps C and O
    load(4'b1100); step(); idle();
    check("load_1100", 8'(r_flag), 8'(with_p(4'b1100)));
    alu(2'b10, 8'h3C, 8'hC3, 8'h00, 1'b1, 4'b0011);
    step(); idle();
    check("logic_mask", 8'(r_flag), 8'h0D);
    load(4'b1100); step(); idle();
    alu(2'b10, 8'h3C, 8'hC3, 8'h00, 1'b1, 4'b0011); flag_we = 0;
    step(); idle();
    check("we_off_hold", 8'(r_flag), 8'(with_p(4'b1100)));

    // fill stack
    for (int i = 0; i < 4; i++) begin
      load(4'(1 << i)); step(); idle();
      save = 1; step(); idle();
    end
    check("fill_full", 8'(stk_full), 8'd1);
    check("fill_empty", 8'(stk_empty), 8'd0);
    save = 1; step(); idle();
    check("push_full_err", 8'(err), 8'd1);
    step();
    check("err_pulse_end", 8'(err), 8'd0);
    check("still_full", 8'(stk_full), 8'd1);
    for (int i = 0; i < 4; i++) begin
      restore = 1; step(); idle();
      check($sformatf("pop%0d", i), 8'(r_flag), 8'(with_p(4'(8 >> i))));
      check($sformatf("pop%0d_err", i), 8'(err), 8'd0);
    end
    check("drain_empty", 8'(stk_empty), 8'd1);
    restore = 1; step(); idle();
    check("pop_empty_err", 8'(err), 8'd1);
    check("pop_empty_hold", 8'(r_flag), 8'(with_p(4'b0001)));
    check("pop_empty_empty", 8'(stk_empty), 8'd1);

    // simultaneous events
    load(4'b0000); step(); idle();
    load(4'b1111); save = 1; step(); idle();
    check("save_we_flags", 8'(r_flag), 8'h0F);
    check("save_we_count", 8'(stk_empty), 8'd0);
    load(4'b0110); restore = 1; step(); idle();
    check("restore_wins", 8'(r_flag), 8'h10);
    check("restore_wins_empty", 8'(stk_empty), 8'd1);
    load(4'b0110); restore = 1; step(); idle();
    check("restore_empty_err", 8'(err), 8'd1);
    check("restore_empty_drop", 8'(r_flag), 8'h10);
    save = 1; step(); idle();
    save = 1; restore = 1; load(4'b0011); step(); idle();
    check("save_restore_err", 8'(err), 8'd1);
    check("save_restore_we", 8'(r_flag), 8'(with_p(4'b0011)));
    check("save_restore_cnt_e", 8'(stk_empty), 8'd0);
    check("save_restore_cnt_f", 8'(stk_full), 8'd0);

    // async reset mid-cycle with two entries stacked
    load(4'b1011); save = 1; step(); idle();
    check("pre_rst_flags", 8'(r_flag), 8'(with_p(4'b1011)));
    #2 rst_n = 0;
    #1;
    check("async_rflag", 8'(r_flag), 8'h10);
    check("async_empty", 8'(stk_empty), 8'd1);
    check("async_err", 8'(err), 8'd0);
    @(negedge clk);
    rst_n = 1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
